ulpi_phy_reg: RTL and testbench
===============================

ULPI_PHY_REG -- requirements
Module: ulpi_phy_reg

Interface
REQ-001 SHALL have parameters: VENDOR_ID, 16'h0424, IDs at 0x00/0x01 (lo/hi); PRODUCT_ID, 16'h0009, IDs at 0x02/0x03; RST_CYCLES, 16, DIR-high cycles for PHY soft reset.
REQ-002 SHALL have ports (name direction width meaning):
CLK_60M  in  1  ULPI clock; one clock; all logic on rising edge.
RST_S_USB  in  1  reset, synchronous, active-high.
USB_DATA_I  in  8  bus value driven by link.
USB_DATA_O  out  8  bus value driven by PHY.
USB_DATA_OE  out  1  PHY drives bus when 1.
USB_DIR  out  1  ULPI dir.
USB_NXT  out  1  ULPI nxt.
USB_STP  in  1  ULPI stp from link.
LINESTATE_I  in  2  line state reported in RXCMD.
VBUS_I  in  2  VBUS state reported in RXCMD.
FUNC_CTRL_O / IFACE_CTRL_O / OTG_CTRL_O / SCRATCH_O  out  8 each  current register contents.
WR_ERR  out  1  one-cycle pulse: write aborted (no stp).

Function
REQ-003 SHALL implement the PHY (responder) end of ULPI register access: TXCMD {2'b10,addr} = write, {2'b11,addr} = read; all outputs registered.
REQ-004 SHALL hold registers: FUNC_CTRL write/set/clear 0x04/0x05/0x06, default 0x41; IFACE_CTRL 0x07/0x08/0x09, default 0x00; OTG_CTRL 0x0A/0x0B/0x0C, default 0x06; SCRATCH 0x16/0x17/0x18, default 0x00; set = OR, clear = AND-NOT, reads at any alias return the register.
REQ-005 SHALL treat 0x00-0x03 as read-only ID bytes; writes to read-only or unmapped addresses handshake normally and are discarded; reads of unmapped addresses return 0x00; addr 6'h2F (extended) SHALL be ignored in IDLE (no nxt).
REQ-006 States: IDLE, W_ACK, W_DATA, W_STP, R_ACK, R_TURN, R_DATA, RX_TURN, RX_DATA, TURN_BACK, PHY_RST.
REQ-007 IDLE: DIR=0, NXT=0, OE=0; USB_DATA_I[7:6]=2'b10 -> latch addr, W_ACK; 2'b11 -> latch addr, R_ACK; else if RXCMD pending -> RX_TURN.
REQ-008 W_ACK: NXT=1 one cycle -> W_DATA; W_DATA: NXT=0, capture USB_DATA_I -> W_STP; W_STP: STP=1 commits write -> IDLE, STP=0 discards, WR_ERR=1 one cycle -> IDLE.
REQ-009 R_ACK: NXT=1 one cycle -> R_TURN (DIR=1, OE=0) -> R_DATA (DIR=1, OE=1, DATA_O=register) -> TURN_BACK (DIR=0, OE=0) -> IDLE; read latency TXCMD-seen to data = 3 cycles.
REQ-010 LINESTATE_I or VBUS_I change (vs last sampled) SHALL set RXCMD pending; RX_TURN (DIR=1, OE=0) -> RX_DATA (DIR=1, OE=1, DATA_O={4'b0000,VBUS_I,LINESTATE_I} sampled now) -> TURN_BACK; pending cleared on entering RX_DATA.
REQ-011 Simultaneous TXCMD and pending RXCMD in IDLE: TXCMD wins; RXCMD sent after transaction returns to IDLE; changes during a transaction are not lost.
REQ-012 Committed write with FUNC_CTRL bit5=1 SHALL enter PHY_RST: DIR=1, OE=0, NXT=0 for RST_CYCLES cycles, all registers reload defaults (bit5 reads 0), RXCMD pending set, then TURN_BACK -> IDLE.
REQ-013 STP=1 in any state other than W_STP SHALL be ignored; USB_DATA_I ignored while DIR=1.

Reset
REQ-014 RST_S_USB=1 at a clock edge SHALL force IDLE, DIR=0, NXT=0, OE=0, DATA_O=0x00, WR_ERR=0, registers to defaults, RXCMD pending=0, sampled line/VBUS state = current inputs; mid-transaction reset abandons transaction without commit.

Verification
REQ-015 Write: TXCMD 0x87, data 0x5A, stp -> NXT=1 one cycle after TXCMD, IFACE_CTRL_O=0x5A after stp cycle.
REQ-016 Set/clear: write 0x96 data 0xF0, then 0x98 data 0x30 -> SCRATCH_O=0xF0 then 0xC0.
REQ-017 Read: TXCMD 0xC2 -> NXT one cycle, DIR 1 turnaround, DATA_O=0x09 with OE=1, DIR low next cycle.
REQ-018 Abort: TXCMD 0x84, data 0x00, no stp -> WR_ERR pulse, FUNC_CTRL_O stays 0x41.
REQ-019 Reset: write 0x84 data 0x61 -> DIR high 16 cycles, FUNC_CTRL_O=0x41, then RXCMD {0000,VBUS_I,LINESTATE_I} sent.
REQ-020 Collision: LINESTATE_I 00->01 same cycle as TXCMD 0xC4 -> read completes first, RXCMD 0x01 follows.

Source files
------------

// File: rtl/ulpi_phy_reg.sv
// ulpi_phy_reg: PHY-side ULPI register responder with ID bytes, set/clear aliases, RXCMD reporting and soft reset.
module ulpi_phy_reg #(
    parameter logic [15:0] VENDOR_ID  = 16'h0424,
    parameter logic [15:0] PRODUCT_ID = 16'h0009,
    parameter int          RST_CYCLES = 16
) (
    input  logic       CLK_60M,
    input  logic       RST_S_USB,
    input  logic [7:0] USB_DATA_I,
    output logic [7:0] USB_DATA_O,
    output logic       USB_DATA_OE,
    output logic       USB_DIR,
    output logic       USB_NXT,
    input  logic       USB_STP,
    input  logic [1:0] LINESTATE_I,
    input  logic [1:0] VBUS_I,
    output logic [7:0] FUNC_CTRL_O,
    output logic [7:0] IFACE_CTRL_O,
    output logic [7:0] OTG_CTRL_O,
    output logic [7:0] SCRATCH_O,
    output logic       WR_ERR
);
    typedef enum logic [3:0] {
        IDLE, W_ACK, W_DATA, W_STP, R_ACK, R_TURN, R_DATA, RX_TURN, RX_DATA, TURN_BACK, PHY_RST
    } state_t;
    localparam logic [3:0][7:0] DEF = {8'h00, 8'h06, 8'h00, 8'h41};
    localparam logic [15:0] RST_LOAD = 16'(RST_CYCLES - 1);
    localparam logic [31:0] IDS = {PRODUCT_ID, VENDOR_ID};
    state_t state, ns;
    logic [3:0][7:0] regs;
    logic [5:0] addr, rel;
    logic [7:0] wdata, cur, nv, rd, data_d;
    logic [15:0] cnt;
    logic [1:0] idx, op, ls_q, vb_q;
    logic hit, txw, txr, commit, rst_go, pend, changed, dir_d, nxt_d, oe_d, err_d;
    assign txw = USB_DATA_I[7:6] == 2'b10 && USB_DATA_I[5:0] != 6'h2F;
    assign txr = USB_DATA_I[7:6] == 2'b11 && USB_DATA_I[5:0] != 6'h2F;
    assign changed = ls_q != LINESTATE_I || vb_q != VBUS_I;
    // Aliases come in triples (write/set/clear); rel maps both banks onto one 0..11 index space.
    always_comb begin
        hit = (addr >= 6'h04 && addr <= 6'h0C) || (addr >= 6'h16 && addr <= 6'h18);
        rel = addr >= 6'h16 ? addr - 6'h0D : addr - 6'h04;
        idx = 2'(rel / 6'd3);
        op = 2'(rel % 6'd3);
        cur = regs[idx];
        nv = op == 2'd0 ? wdata : op == 2'd1 ? cur | wdata : cur & ~wdata;
        commit = state == W_STP && USB_STP && hit;
        rst_go = commit && idx == 2'd0 && nv[5];
        rd = addr <= 6'h03 ? IDS[{addr[1:0], 3'b000} +: 8] : hit ? cur : 8'h00;
    end
    always_ff @(posedge CLK_60M) begin
        if (RST_S_USB) begin
            state <= IDLE;
            regs <= DEF;
            pend <= 1'b0;
            ls_q <= LINESTATE_I;
            vb_q <= VBUS_I;
            cnt <= '0;
            addr <= '0;
            wdata <= '0;
            USB_DIR <= 1'b0;
            USB_NXT <= 1'b0;
            USB_DATA_OE <= 1'b0;
            USB_DATA_O <= 8'h00;
            WR_ERR <= 1'b0;
        end else begin
            state <= ns;
            ls_q <= LINESTATE_I;
            vb_q <= VBUS_I;
            pend <= ns == RX_DATA ? 1'b0 : pend | changed | rst_go;
            if (state == IDLE && (txw || txr)) addr <= USB_DATA_I[5:0];
            if (state == W_DATA) wdata <= USB_DATA_I;
            if (rst_go) regs <= DEF;
            else if (commit) regs[idx] <= nv;
            cnt <= rst_go ? RST_LOAD : state == PHY_RST ? cnt - 16'd1 : cnt;
            USB_DIR <= dir_d;
            USB_NXT <= nxt_d;
            USB_DATA_OE <= oe_d;
            USB_DATA_O <= data_d;
            WR_ERR <= err_d;
        end
    end
    always_comb begin
        ns = IDLE;
        case (state)
            IDLE:      ns = txw ? W_ACK : txr ? R_ACK : pend ? RX_TURN : IDLE;
            W_ACK:     ns = W_DATA;
            W_DATA:    ns = W_STP;
            W_STP:     ns = rst_go ? PHY_RST : IDLE;
            R_ACK:     ns = R_TURN;
            R_TURN:    ns = R_DATA;
            R_DATA:    ns = TURN_BACK;
            RX_TURN:   ns = RX_DATA;
            RX_DATA:   ns = TURN_BACK;
            PHY_RST:   ns = cnt == 16'd0 ? TURN_BACK : PHY_RST;
            default:   ns = IDLE;
        endcase
    end
    always_comb begin
        dir_d = ns inside {R_TURN, R_DATA, RX_TURN, RX_DATA, PHY_RST};
        nxt_d = ns inside {W_ACK, R_ACK};
        oe_d = ns inside {R_DATA, RX_DATA};
        data_d = ns == R_DATA ? rd : ns == RX_DATA ? {4'b0000, VBUS_I, LINESTATE_I} : 8'h00;
        err_d = state == W_STP && !USB_STP;
    end
    assign FUNC_CTRL_O = regs[0];
    assign IFACE_CTRL_O = regs[1];
    assign OTG_CTRL_O = regs[2];
    assign SCRATCH_O = regs[3];
endmodule

// File: tb/tb_ulpi_phy_reg.sv
// tb_ulpi_phy_reg: directed and randomized ULPI link-side stimulus against a register-map model.
module tb_ulpi_phy_reg;
    logic CLK_60M = 1'b0;
    logic RST_S_USB = 1'b1;
    logic [7:0] USB_DATA_I = 8'h00;
    logic USB_STP = 1'b0;
    logic [1:0] LINESTATE_I = 2'b00;
    logic [1:0] VBUS_I = 2'b00;
    logic [7:0] USB_DATA_O, FUNC_CTRL_O, IFACE_CTRL_O, OTG_CTRL_O, SCRATCH_O;
    logic USB_DATA_OE, USB_DIR, USB_NXT, WR_ERR;
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] m [4];

    ulpi_phy_reg dut (
        .CLK_60M(CLK_60M), .RST_S_USB(RST_S_USB), .USB_DATA_I(USB_DATA_I), .USB_DATA_O(USB_DATA_O),
        .USB_DATA_OE(USB_DATA_OE), .USB_DIR(USB_DIR), .USB_NXT(USB_NXT), .USB_STP(USB_STP),
        .LINESTATE_I(LINESTATE_I), .VBUS_I(VBUS_I), .FUNC_CTRL_O(FUNC_CTRL_O), .IFACE_CTRL_O(IFACE_CTRL_O),
        .OTG_CTRL_O(OTG_CTRL_O), .SCRATCH_O(SCRATCH_O), .WR_ERR(WR_ERR)
    );

    always #8 CLK_60M = ~CLK_60M;

    task automatic step;
        @(posedge CLK_60M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset;
        m[0] = 8'h41;
        m[1] = 8'h00;
        m[2] = 8'h06;
        m[3] = 8'h00;
    endtask

    function automatic int base_of(input int k);
        return k == 0 ? 4 : k == 1 ? 7 : k == 2 ? 10 : 22;
    endfunction

    function automatic int reg_of(input int a);
        for (int k = 0; k < 4; k++)
            if (a >= base_of(k) && a < base_of(k) + 3) return k;
        return -1;
    endfunction

    function automatic logic [7:0] model_rd(input int a);
        int k;
        if (a == 0) return 8'h24;
        if (a == 1) return 8'h04;
        if (a == 2) return 8'h09;
        if (a == 3) return 8'h00;
        k = reg_of(a);
        return k >= 0 ? m[k] : 8'h00;
    endfunction

    task automatic chk_regs;
        chk("func_ctrl", FUNC_CTRL_O, m[0]);
        chk("iface_ctrl", IFACE_CTRL_O, m[1]);
        chk("otg_ctrl", OTG_CTRL_O, m[2]);
        chk("scratch", SCRATCH_O, m[3]);
    endtask

    task automatic expect_rxcmd(input logic [7:0] exp);
        for (int i = 0; i < 24; i++) begin
            if (USB_DIR && USB_DATA_OE) break;
            step;
        end
        chk("rxcmd_seen", {USB_DIR, USB_DATA_OE}, 2'b11);
        chk("rxcmd_data", USB_DATA_O, exp);
        step;
        chk("rxcmd_turn", USB_DIR, 1'b0);
        step;
        step;
        chk("rxcmd_once", USB_DIR, 1'b0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d, input bit stp);
        int k, op;
        logic [7:0] nv;
        bit prst;
        k = reg_of(int'(a));
        prst = 0;
        USB_DATA_I = {2'b10, a};
        step;
        chk("wr_nxt", USB_NXT, 1'b1);
        chk("wr_dir", USB_DIR, 1'b0);
        USB_DATA_I = d;
        step;
        chk("wr_nxt_low", USB_NXT, 1'b0);
        step;
        USB_DATA_I = 8'h00;
        USB_STP = stp;
        step;
        USB_STP = 1'b0;
        if (stp && k >= 0) begin
            op = int'(a) - base_of(k);
            nv = op == 0 ? d : op == 1 ? (m[k] | d) : (m[k] & ~d);
            if (k == 0 && nv[5]) begin
                prst = 1;
                model_reset;
            end else m[k] = nv;
        end
        chk("wr_err", WR_ERR, !stp);
        chk_regs;
        if (prst) begin
            for (int i = 0; i < 16; i++) begin
                chk("phyrst_dir", {USB_DIR, USB_DATA_OE, USB_NXT}, 3'b100);
                step;
            end
            chk("phyrst_end", USB_DIR, 1'b0);
            expect_rxcmd({4'b0000, VBUS_I, LINESTATE_I});
        end else begin
            step;
            chk("wr_err_pulse", WR_ERR, 1'b0);
        end
    endtask

    task automatic rd(input logic [5:0] a);
        logic [7:0] e;
        e = model_rd(int'(a));
        USB_DATA_I = {2'b11, a};
        step;
        chk("rd_nxt", USB_NXT, 1'b1);
        chk("rd_dir0", USB_DIR, 1'b0);
        USB_DATA_I = 8'h00;
        step;
        chk("rd_turn", {USB_DIR, USB_DATA_OE, USB_NXT}, 3'b100);
        step;
        chk("rd_drive", {USB_DIR, USB_DATA_OE}, 2'b11);
        chk("rd_data", USB_DATA_O, e);
        step;
        chk("rd_back", {USB_DIR, USB_DATA_OE}, 2'b00);
        step;
    endtask

    initial begin
        logic [1:0] nls, nvb;
        logic [5:0] a;
        model_reset;
        step;
        step;
        step;
        chk("rst_out", {USB_DIR, USB_NXT, USB_DATA_OE, WR_ERR}, 4'b0000);
        chk("rst_data", USB_DATA_O, 8'h00);
        RST_S_USB = 1'b0;
        chk_regs;
        wr(6'h07, 8'h5A, 1);
        wr(6'h16, 8'hF0, 1);
        wr(6'h18, 8'h30, 1);
        rd(6'h02);
        wr(6'h04, 8'h00, 0);
        USB_DATA_I = 8'hAF;
        step;
        chk("ext_nxt", USB_NXT, 1'b0);
        USB_DATA_I = 8'h00;
        step;
        chk("ext_idle", {USB_DIR, USB_NXT}, 2'b00);
        wr(6'h00, 8'hFF, 1);
        rd(6'h00);
        rd(6'h01);
        rd(6'h20);
        rd(6'h17);
        LINESTATE_I = 2'b10;
        VBUS_I = 2'b11;
        expect_rxcmd(8'h0E);
        wr(6'h04, 8'h61, 1);
        LINESTATE_I = 2'b00;
        VBUS_I = 2'b00;
        expect_rxcmd(8'h00);
        LINESTATE_I = 2'b01;
        rd(6'h04);
        expect_rxcmd(8'h01);
        USB_DATA_I = {2'b10, 6'h07};
        step;
        USB_DATA_I = 8'h33;
        step;
        step;
        USB_STP = 1'b1;
        RST_S_USB = 1'b1;
        step;
        RST_S_USB = 1'b0;
        USB_STP = 1'b0;
        USB_DATA_I = 8'h00;
        model_reset;
        chk_regs;
        step;
        step;
        chk("midrst_idle", {USB_DIR, USB_NXT, WR_ERR}, 3'b000);
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                nls = 2'($urandom);
                nvb = 2'($urandom);
                if (nls != LINESTATE_I || nvb != VBUS_I) begin
                    LINESTATE_I = nls;
                    VBUS_I = nvb;
                    expect_rxcmd({4'b0000, nvb, nls});
                end
            end
            do a = 6'($urandom); while (a == 6'h2F);
            if ($urandom_range(0, 1) == 1 || it % 5 == 0) begin
                if (it % 3 == 0) a = 6'(base_of(int'($urandom_range(0, 3))) + int'($urandom_range(0, 2)));
                wr(a, 8'($urandom), $urandom_range(0, 9) < 8);
            end else rd(a);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
